// File: rtl/bit_pattern_gen.sv
// bit_pattern_gen: multi-channel step/pulse/PRBS/clock bit source, one start/busy/done transaction per pattern.
// Latency: start sampled at edge t -> first RUN bit visible after edge t+1+dly; every output is registered.
// Backpressure: none; start is ignored outside IDLE. BIT_PATTERN_GEN_ERRINJ_EN adds single-cycle error injection.
module bit_pattern_gen #(
    parameter int                    N_CH       = 2,
    parameter int                    CNT_W      = 16,
    parameter int                    PRBS_ORDER = 7,
    parameter logic [PRBS_ORDER-1:0] SEED       = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] dly,
    input  logic [CNT_W-1:0] len,
    input  logic [N_CH-1:0]  ch_en,
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
    input  logic             err_en,
    input  logic [CNT_W-1:0] err_idx,
`endif
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [N_CH-1:0]  out
);

    generate
        if (!(PRBS_ORDER == 7 || PRBS_ORDER == 15)) begin : g_bad_order
            $error("bit_pattern_gen: PRBS_ORDER must be 7 or 15");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("bit_pattern_gen: SEED must be nonzero");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    localparam logic [2:0] M_STEP  = 3'd1;
    localparam logic [2:0] M_PULSE = 3'd2;
    localparam logic [2:0] M_PRBS  = 3'd3;
    localparam logic [2:0] M_CLK   = 3'd4;

    state_t                state_q, state_nxt;
    logic [2:0]            mode_q;
    logic [CNT_W-1:0]      dly_q, len_q, cnt_q;
    logic [N_CH-1:0]       ch_en_q;
    logic [PRBS_ORDER-1:0] lfsr_q;
    logic                  hold_q;
    logic                  accept, dly_last, run_last;
    logic [N_CH-1:0]       prbs_bits, pat, out_nxt;
    logic                  busy_nxt, done_nxt, valid_nxt;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
    logic                  err_en_q;
    logic [CNT_W-1:0]      err_idx_q;
`endif

    assign accept   = (state_q == S_IDLE) && start;
    assign dly_last = (cnt_q == dly_q - CNT_W'(1));
    assign run_last = (cnt_q == len_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dly != '0)      state_nxt = S_DELAY;
                    else if (len != '0) state_nxt = S_RUN;
                    else                state_nxt = S_DONE;
                end
            end
            S_DELAY: if (dly_last) state_nxt = (len_q != '0) ? S_RUN : S_DONE;
            S_RUN:   if (run_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt_q restarts from 0 on every state entry, so in RUN it is the RUN cycle index.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= '0;
            dly_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ch_en_q   <= '0;
            lfsr_q    <= SEED;
            hold_q    <= 1'b0;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
            err_en_q  <= 1'b0;
            err_idx_q <= '0;
`endif
        end else if (accept) begin
            mode_q    <= mode;
            dly_q     <= dly;
            len_q     <= len;
            ch_en_q   <= ch_en;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            hold_q    <= 1'b0;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
            err_en_q  <= err_en;
            err_idx_q <= err_idx;
`endif
        end else if (state_q == S_DELAY) begin
            cnt_q <= dly_last ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q == S_RUN) begin
            cnt_q  <= run_last ? '0 : cnt_q + CNT_W'(1);
            lfsr_q <= {lfsr_q[PRBS_ORDER-2:0], lfsr_q[PRBS_ORDER-1] ^ lfsr_q[PRBS_ORDER-2]};
            if (mode_q == M_STEP) hold_q <= 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            prbs_bits[k] = lfsr_q[PRBS_ORDER-1-(k % PRBS_ORDER)];
        end
        case (mode_q)
            M_STEP, M_PULSE: pat = '1;
            M_PRBS:          pat = prbs_bits;
            M_CLK:           pat = {N_CH{~cnt_q[0]}};
            default:         pat = '0;
        endcase
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
        if (err_en_q && (cnt_q == err_idx_q)) pat = ~pat;
`endif
        busy_nxt  = (state_q == S_DELAY) || (state_q == S_RUN);
        valid_nxt = (state_q == S_RUN);
        done_nxt  = (state_q == S_DONE);
        // hold_q is cleared on accept, so it can only show in DONE and IDLE.
        if (state_q == S_RUN) out_nxt = pat & ch_en_q;
        else if (hold_q)      out_nxt = ch_en_q;
        else                  out_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            out   <= '0;
        end else begin
            busy  <= busy_nxt;
            done  <= done_nxt;
            valid <= valid_nxt;
            out   <= out_nxt;
        end
    end

endmodule

// File: tb/tb_bit_pattern_gen.sv
// Randomized bench for bit_pattern_gen against a sequence-level reference model.
module tb_bit_pattern_gen;
    localparam int N = 2;
    localparam int W = 8;
    localparam int O = 7;
    localparam logic [O-1:0] SEED_V = 7'h7F;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   mode;
    logic [W-1:0] dly, len;
    logic [N-1:0] ch_en;
    logic         busy, done, valid;
    logic [N-1:0] out;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
    logic         err_en;
    logic [W-1:0] err_idx;
`endif

    int total = 0;
    int bad = 0;
    bit c_seq [0:1023];
    logic [N-1:0] hold_lvl;
    bit obs0[$];
    bit obs1[$];
    bit x_err_en = 1'b0;
    int x_err_idx = 0;

    always #5 clk = ~clk;

    bit_pattern_gen #(.N_CH(N), .CNT_W(W), .PRBS_ORDER(O), .SEED(SEED_V)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dly(dly), .len(len), .ch_en(ch_en),
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
        .err_en(err_en), .err_idx(err_idx),
`endif
        .busy(busy), .done(done), .valid(valid), .out(out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Channel k in RUN cycle r carries the ch0 stream shifted by k mod O.
    function automatic logic [N-1:0] pattern(input logic [2:0] m, input int r, input logic [N-1:0] en);
        logic [N-1:0] p;
        p = '0;
        case (m)
            3'd1, 3'd2: p = '1;
            3'd3: for (int k = 0; k < N; k++) p[k] = c_seq[r + (k % O)];
            3'd4: p = (r % 2 == 0) ? '1 : '0;
            default: p = '0;
        endcase
        if (x_err_en && r == x_err_idx) p = ~p;
        return p & en;
    endfunction

    // Expected {busy,done,valid,out} sampled after edge t+j, where t samples start.
    function automatic logic [N+2:0] expect_at(input int j, input logic [2:0] m, input int d, input int l,
                                               input logic [N-1:0] en, input logic [N-1:0] prev);
        logic [N-1:0] post;
        post = (m == 3'd1 && l > 0) ? en : '0;
        if (j == 0)         return {3'b000, prev};
        if (j <= d)         return {3'b100, {N{1'b0}}};
        if (j <= d + l)     return {3'b101, pattern(m, j - d - 1, en)};
        if (j == d + l + 1) return {3'b010, post};
        return {3'b000, post};
    endfunction

    task automatic run_txn(input logic [2:0] m, input int d, input int l, input logic [N-1:0] en,
                           input bit junk, input int rst_at);
        int last;
        last = d + l + 2;
        start = 1'b1; mode = m; dly = W'(d); len = W'(l); ch_en = en;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
        err_en = x_err_en; err_idx = W'(x_err_idx);
`endif
        for (int j = 0; j <= last; j++) begin
            @(posedge clk); @(negedge clk);
            check("cyc", 32'({busy, done, valid, out}), 32'(expect_at(j, m, d, l, en, hold_lvl)));
            if (valid) begin
                obs0.push_back(out[0]);
                obs1.push_back(out[1]);
            end
            if (j == rst_at) begin
                rst = 1'b1; start = 1'b0;
                @(posedge clk); @(negedge clk);
                check("rst_mid", 32'({busy, done, valid, out}), 32'h0);
                rst = 1'b0;
                repeat (2) begin
                    @(posedge clk); @(negedge clk);
                    check("post_rst", 32'({busy, done, valid, out}), 32'h0);
                end
                hold_lvl = '0;
                return;
            end
            if (junk && j + 1 <= d + l + 1) begin
                start = 1'($urandom); mode = 3'($urandom); dly = W'($urandom);
                len = W'($urandom); ch_en = N'($urandom);
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
                err_en = 1'($urandom); err_idx = W'($urandom);
`endif
            end else begin
                start = 1'b0;
            end
        end
        hold_lvl = (m == 3'd1 && l > 0) ? en : '0;
    endtask

    initial begin
        int ones, miss;
        logic [7:0] seq;
        for (int i = 0; i < O; i++) c_seq[i] = SEED_V[O-1-i];
        for (int i = 0; i + O < 1024; i++) c_seq[i+O] = c_seq[i] ^ c_seq[i+1];
        hold_lvl = '0;
        rst = 1'b1; start = 1'b1; mode = 3'd2; dly = 8'd3; len = 8'd4; ch_en = '1;
`ifdef BIT_PATTERN_GEN_ERRINJ_EN
        err_en = 1'b0; err_idx = '0;
`endif
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("reset", 32'({busy, done, valid, out}), 32'h0);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("idle", 32'({busy, done, valid, out}), 32'h0);

        run_txn(3'd2, 5, 20, 2'b11, 1'b0, -1);
        run_txn(3'd1, 0, 3, 2'b11, 1'b0, -1);
        run_txn(3'd2, 2, 4, 2'b11, 1'b0, -1);
        run_txn(3'd1, 1, 2, 2'b01, 1'b1, -1);
        run_txn(3'd4, 0, 7, 2'b10, 1'b1, -1);
        run_txn(3'd2, 0, 0, 2'b11, 1'b0, -1);
        run_txn(3'd1, 3, 0, 2'b11, 1'b1, -1);
        run_txn(3'd6, 1, 3, 2'b11, 1'b0, -1);

        obs0.delete(); obs1.delete();
        run_txn(3'd3, 1, 254, 2'b11, 1'b1, -1);
        check("prbs_len", 32'(obs0.size()), 32'd254);
        if (obs0.size() == 254 && obs1.size() == 254) begin
            ones = 0;
            for (int i = 0; i < 7; i++) ones += int'(obs0[i]);
            check("prbs_first7", 32'(ones), 32'd7);
            ones = 0;
            for (int i = 0; i < 127; i++) ones += int'(obs0[i]);
            check("prbs_ones", 32'(ones), 32'd64);
            miss = 0;
            for (int i = 0; i < 127; i++) if (obs0[i] != obs0[i+127]) miss++;
            check("prbs_period", 32'(miss), 32'd0);
            miss = 0;
            for (int i = 0; i < 253; i++) if (obs1[i] != obs0[i+1]) miss++;
            check("prbs_shift", 32'(miss), 32'd0);
        end

        run_txn(3'd4, 255, 255, 2'b11, 1'b0, -1);
        run_txn(3'd1, 3, 30, 2'b11, 1'b1, 13);
        run_txn(3'd2, 0, 2, 2'b11, 1'b0, 2);

        repeat (40) begin
            run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 6), $urandom_range(0, 20),
                    N'($urandom), 1'($urandom_range(0, 1)), -1);
        end

`ifdef BIT_PATTERN_GEN_ERRINJ_EN
        x_err_en = 1'b1; x_err_idx = 3;
        obs0.delete(); obs1.delete();
        run_txn(3'd4, 0, 8, 2'b11, 1'b0, -1);
        seq = '0;
        foreach (obs0[i]) seq = {seq[6:0], obs0[i]};
        check("errinj_seq", 32'(seq), 32'hBA);
        x_err_idx = 9;
        run_txn(3'd4, 1, 8, 2'b11, 1'b1, -1);
        x_err_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
